// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory arbiter.
// State and owner encodings plus default bus widths.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Bit 0 is the IFU, bit 1 is the LSU.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On a tie the master that did not win last time goes next
  always_comb begin
    gnt_o = req_i;
    if (&req_i)
      gnt_o = (last_i == OWN_LSU) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store.
// One outstanding transaction with timeout abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                ls_valid_i,
  output logic                ls_ready_o,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic                ls_wen_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i,
  output logic                busy_o
);

  localparam int MW    = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mval_q, mval_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              mwen_q, mwen_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [MW-1:0]     mwmask_q, mwmask_d;
  logic              ifrv_q, ifrv_d;
  logic [DATA_W-1:0] ifrd_q, ifrd_d;
  logic              iferr_q, iferr_d;
  logic              lsrv_q, lsrv_d;
  logic [DATA_W-1:0] lsrd_q, lsrd_d;
  logic              lserr_q, lserr_d;

  logic [1:0]        gnt;
  logic              idle;
  logic              rsp;
  logic              abort;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  rr_arb2 u_rr (
    .req_i  ({ls_valid_i, if_valid_i}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign idle = (state_q == S_IDLE);

  // Grant is visible only while idle
  always_comb begin
    if_ready_o = idle & gnt[0];
    ls_ready_o = idle & gnt[1];
  end

  // FSM, payload capture, timeout and response routing
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    mval_d   = mval_q;
    maddr_d  = maddr_q;
    mwen_d   = mwen_q;
    mwdata_d = mwdata_q;
    mwmask_d = mwmask_q;
    ifrv_d   = 1'b0;
    ifrd_d   = ifrd_q;
    iferr_d  = iferr_q;
    lsrv_d   = 1'b0;
    lsrd_d   = lsrd_q;
    lserr_d  = lserr_q;
    rsp      = 1'b0;
    abort    = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          cnt_d   = '0;
          mval_d  = 1'b1;
          state_d = S_REQ;
          if (gnt[1]) begin
            maddr_d  = ls_addr_i;
            mwen_d   = ls_wen_i;
            mwdata_d = ls_wdata_i;
            mwmask_d = ls_wmask_i;
          end else begin
            maddr_d  = if_addr_i;
            mwen_d   = 1'b0;
            mwdata_d = '0;
            mwmask_d = '1;
          end
        end
      end
      S_REQ: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
        if (mem_ready_i) begin
          mval_d  = 1'b0;
          state_d = S_RESP;
          if (mem_rvalid_i) begin
            rsp     = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (!rsp && cnt_q == CNT_LAST)
          abort = 1'b1;
      end
      S_RESP: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          rsp     = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      mval_d  = 1'b0;
      state_d = S_IDLE;
    end
    if (rsp) begin
      rsp_data = mwen_q ? '0 : mem_rdata_i;
      rsp_err  = mem_err_i;
    end else begin
      rsp_err  = 1'b1;
    end
    if (rsp || abort) begin
      if (owner_q == OWN_LSU) begin
        lsrv_d  = 1'b1;
        lsrd_d  = rsp_data;
        lserr_d = rsp_err;
      end else begin
        ifrv_d  = 1'b1;
        ifrd_d  = rsp_data;
        iferr_d = rsp_err;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IFU;
      last_q   <= OWN_LSU;
      cnt_q    <= '0;
      mval_q   <= 1'b0;
      maddr_q  <= '0;
      mwen_q   <= 1'b0;
      mwdata_q <= '0;
      mwmask_q <= '0;
      ifrv_q   <= 1'b0;
      ifrd_q   <= '0;
      iferr_q  <= 1'b0;
      lsrv_q   <= 1'b0;
      lsrd_q   <= '0;
      lserr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      mval_q   <= mval_d;
      maddr_q  <= maddr_d;
      mwen_q   <= mwen_d;
      mwdata_q <= mwdata_d;
      mwmask_q <= mwmask_d;
      ifrv_q   <= ifrv_d;
      ifrd_q   <= ifrd_d;
      iferr_q  <= iferr_d;
      lsrv_q   <= lsrv_d;
      lsrd_q   <= lsrd_d;
      lserr_q  <= lserr_d;
    end
  end

  assign mem_valid_o = mval_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wen_o   = mwen_q;
  assign mem_wdata_o = mwdata_q;
  assign mem_wmask_o = mwmask_q;
  assign if_rvalid_o = ifrv_q;
  assign if_rdata_o  = ifrd_q;
  assign if_err_o    = iferr_q;
  assign ls_rvalid_o = lsrv_q;
  assign ls_rdata_o  = lsrd_q;
  assign ls_err_o    = lserr_q;
  assign busy_o      = ~idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Inputs change 2ns after the edge, checks 1ns later.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_valid_i = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_addr_i = '0;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        ls_valid_i = 1'b0;
  logic        ls_ready_o;
  logic [31:0] ls_addr_i = '0;
  logic        ls_wen_i = 1'b0;
  logic [31:0] ls_wdata_i = '0;
  logic [3:0]  ls_wmask_i = '0;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        ls_err_o;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_wen_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        busy_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_if = 0;
  int n_ls = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_addr_i(if_addr_i), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o),
    .ls_addr_i(ls_addr_i), .ls_wen_i(ls_wen_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .ls_err_o(ls_err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .busy_o(busy_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    logic exp_if;

    // reset state
    do_reset();
    #1;
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid_o), 32'd0);

    // IFU-only fetch, zero-wait slave
    if_valid_i  = 1'b1;
    if_addr_i   = 32'h8000_0000;
    mem_ready_i = 1'b1;
    #1;
    chk("f_if_ready", 32'(if_ready_o), 32'd1);
    chk("f_ls_ready", 32'(ls_ready_o), 32'd0);
    tick();
    if_valid_i = 1'b0;
    #1;
    chk("f_mem_valid", 32'(mem_valid_o), 32'd1);
    chk("f_mem_addr", mem_addr_o, 32'h8000_0000);
    chk("f_mem_wen", 32'(mem_wen_o), 32'd0);
    chk("f_mem_mask", 32'(mem_wmask_o), 32'hf);
    chk("f_busy", 32'(busy_o), 32'd1);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0413;
    #1;
    chk("f_mem_valid_lo", 32'(mem_valid_o), 32'd0);
    chk("f_if_rvalid_t2", 32'(if_rvalid_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("f_if_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("f_if_rdata", if_rdata_o, 32'h0000_0413);
    chk("f_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    chk("f_busy_lo", 32'(busy_o), 32'd0);
    tick();
    #1;
    chk("f_if_pulse", 32'(if_rvalid_o), 32'd0);
    chk("f_if_hold", if_rdata_o, 32'h0000_0413);

    // both masters request continuously from reset
    do_reset();
    if_valid_i  = 1'b1;
    if_addr_i   = 32'h100;
    ls_valid_i  = 1'b1;
    ls_addr_i   = 32'h200;
    ls_wen_i    = 1'b0;
    mem_ready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_if = (t % 2 == 0);
      #1;
      chk($sformatf("rr_if_ready%0d", t),
          32'(if_ready_o), 32'(exp_if));
      chk($sformatf("rr_ls_ready%0d", t),
          32'(ls_ready_o), 32'(!exp_if));
      if (if_rvalid_o) n_if++;
      if (ls_rvalid_o) n_ls++;
      tick();
      #1;
      chk($sformatf("rr_addr%0d", t), mem_addr_o,
          exp_if ? 32'h100 : 32'h200);
      if (if_rvalid_o) n_if++;
      if (ls_rvalid_o) n_ls++;
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'(t + 1);
      #1;
      if (if_rvalid_o) n_if++;
      if (ls_rvalid_o) n_ls++;
      tick();
      mem_rvalid_i = 1'b0;
    end
    if_valid_i = 1'b0;
    ls_valid_i = 1'b0;
    #1;
    if (if_rvalid_o) n_if++;
    if (ls_rvalid_o) n_ls++;
    chk("rr_ls_rdata", ls_rdata_o, 32'd4);
    chk("rr_if_count", 32'(n_if), 32'd2);
    chk("rr_ls_count", 32'(n_ls), 32'd2);
    tick();

    // LSU write, slave answers in the accept cycle
    ls_valid_i = 1'b1;
    ls_addr_i  = 32'h8000_1004;
    ls_wen_i   = 1'b1;
    ls_wdata_i = 32'hDEAD_BEEF;
    ls_wmask_i = 4'b0011;
    #1;
    chk("w_ls_ready", 32'(ls_ready_o), 32'd1);
    tick();
    ls_valid_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("w_mem_wen", 32'(mem_wen_o), 32'd1);
    chk("w_mem_mask", 32'(mem_wmask_o), 32'h3);
    chk("w_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("w_mem_addr", mem_addr_o, 32'h8000_1004);
    tick();
    mem_rvalid_i = 1'b0;
    ls_wen_i     = 1'b0;
    #1;
    chk("w_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    chk("w_ls_rdata", ls_rdata_o, 32'd0);
    chk("w_ls_err", 32'(ls_err_o), 32'd0);
    chk("w_busy", 32'(busy_o), 32'd0);
    tick();

    // slave backpressure for three cycles
    if_valid_i  = 1'b1;
    if_addr_i   = 32'h8000_0010;
    mem_ready_i = 1'b0;
    #1;
    chk("bp_if_ready", 32'(if_ready_o), 32'd1);
    tick();
    ls_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k), 32'(mem_valid_o), 32'd1);
      chk($sformatf("bp_addr%0d", k), mem_addr_o, 32'h8000_0010);
      chk($sformatf("bp_rdy%0d", k),
          32'({if_ready_o, ls_ready_o}), 32'd0);
      tick();
    end
    if_valid_i  = 1'b0;
    ls_valid_i  = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    chk("bp_valid3", 32'(mem_valid_o), 32'd1);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_CAFE;
    mem_err_i    = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    #1;
    chk("bp_if_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("bp_if_rdata", if_rdata_o, 32'h0000_CAFE);
    chk("bp_if_err", 32'(if_err_o), 32'd1);
    tick();

    // timeout: slave never answers
    ls_valid_i  = 1'b1;
    ls_addr_i   = 32'h8000_2000;
    mem_rdata_i = 32'h5555_5555;
    #1;
    chk("to_ls_ready", 32'(ls_ready_o), 32'd1);
    tick();
    ls_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("to_busy%0d", k), 32'(busy_o), 32'd1);
      chk($sformatf("to_rv%0d", k), 32'(ls_rvalid_o), 32'd0);
      tick();
    end
    #1;
    chk("to_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    chk("to_ls_err", 32'(ls_err_o), 32'd1);
    chk("to_ls_rdata", ls_rdata_o, 32'd0);
    chk("to_busy_lo", 32'(busy_o), 32'd0);
    tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("to_late_ls", 32'(ls_rvalid_o), 32'd0);
    chk("to_late_if", 32'(if_rvalid_o), 32'd0);
    tick();

    // reset in RESP drops the transaction
    if_valid_i = 1'b1;
    if_addr_i  = 32'h8000_0020;
    #1;
    chk("rm_if_ready", 32'(if_ready_o), 32'd1);
    tick();
    if_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("rm_in_resp", 32'(busy_o), 32'd1);
    tick();
    rst_i        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0BAD;
    #1;
    chk("rm_busy", 32'(busy_o), 32'd0);
    chk("rm_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rm_mem_addr", mem_addr_o, 32'd0);
    chk("rm_if_rdata", if_rdata_o, 32'd0);
    chk("rm_ls_err", 32'(ls_err_o), 32'd0);
    chk("rm_rvalids", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    tick();
    mem_rvalid_i = 1'b0;
    if_valid_i   = 1'b1;
    ls_valid_i   = 1'b1;
    #1;
    chk("rm_late_if", 32'(if_rvalid_o), 32'd0);
    chk("rm_late_rdata", if_rdata_o, 32'd0);
    chk("rm_tie_if", 32'(if_ready_o), 32'd1);
    chk("rm_tie_ls", 32'(ls_ready_o), 32'd0);
    tick();
    if_valid_i = 1'b0;
    ls_valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
